wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter. It merges results from the ALU and load/store result buses into the single register-file write path. It buffers one result per source, grants one write per cycle, and drives the one-hot per-register write-back strobes and shared write data consumed by the register cells. A write-back strobe is what clears a cell's write-reserve bit, so this block also retires the register reservations made at issue.

## Interface
Parameters:
- W_OPR, 32 (from params.v): operand/data width.
- N_REG, 32: number of architectural registers.
- W_RIDX, 5: register index width, equal to log2(N_REG).

Ports:
- clk, in, 1: clock.
- rst, in, 1: asynchronous, active-low reset.
- alu_valid_i, in, 1: ALU result valid.
- alu_ready_o, out, 1: ALU slot can accept.
- alu_rd_i, in, W_RIDX: ALU destination register.
- alu_data_i, in, W_OPR: ALU result.
- mem_valid_i, in, 1: load result valid.
- mem_ready_o, out, 1: load slot can accept.
- mem_rd_i, in, W_RIDX: load destination register.
- mem_data_i, in, W_OPR: load data.
- wb_o, out, N_REG: one-hot write-back strobes, bit n goes to register cell n's wb_i.
- wb_data_o, out, W_OPR: write data, common to all cells' data_i.
- wb_busy_o, out, 1: at least one slot is occupied.

## Operation
- Each source has a one-entry slot holding valid, rd and data.
- A slot loads on the rising clk edge when valid_i and ready_o are both high.
- ready_o = ~slot_valid | slot_granted. A granted slot may be refilled on the same edge it drains (full throughput, no bubble).
- Arbiter (combinational, from slot states only):
  - Neither slot valid: no grant.
  - Exactly one slot valid: that slot is granted.
  - Both slots valid: arbitration per Configuration.
- At the edge following a grant:
  - wb_o is set to the one-hot decode of the granted rd.
  - wb_data_o is set to the granted data.
  - The granted slot is cleared, unless it is refilled on that edge.
- With no grant, the next edge sets wb_o = 0. wb_data_o holds its last value.
- wb_o never has more than one bit set.
- wb_busy_o = alu slot valid | mem slot valid.
- All register indices, including 0, are written normally.
- Upstream contract: the issue stage never has two results to the same rd in flight, because it stalls on that register's w_reserve_o. The arbiter does not reorder writes to the same rd and does not check for this.
- Reset (asynchronous, any time, including with slots full):
  - Both slots are cleared and their contents discarded.
  - wb_o = 0, wb_data_o = 0, wb_busy_o = 0.
  - alu_ready_o = mem_ready_o = 1.
  - Round-robin pointer is reset to "mem last".

## Timing
- Latency: input handshake at edge k → wb_o/wb_data_o valid during cycle k+1 → register cell captures at edge k+2.
- Sustained throughput: one write-back per cycle in total across both sources.
- Under contention, the losing slot holds and its ready_o stays low until it is granted. No more than one cycle of holding occurs with round-robin.
- Inputs are sampled only on a handshake. Changes to rd/data while ready_o is low are ignored.
- All outputs are registered except ready_o and wb_busy_o, which are combinational from slot state and grant.

## Configuration
- WB_RR_EN defined: round-robin arbitration.
  - A 1-bit last-grant pointer is updated on every grant.
  - On contention, the source not granted last wins.
  - After reset, ALU wins the first contention.
- WB_RR_EN undefined: fixed priority, mem always beats ALU. No pointer register is built, and an ALU result may be held indefinitely under continuous loads.

## Test plan
- Reset with both slots full (alu rd=3, mem rd=7) → wb_o=0 and wb_data_o=0 immediately. Both ready_o=1, wb_busy_o=0, and no strobe appears afterward.
- Single ALU write of rd=5, data=0xDEADBEEF at edge k → during cycle k+1, wb_o=0x00000020 and wb_data_o=0xDEADBEEF. During cycle k+2, wb_o=0.
- Both sources valid at the same edge (alu rd=1, data=0x11; mem rd=2, data=0x22):
  - Fixed priority: mem write comes out first, ALU write the cycle after.
  - With WB_RR_EN: ALU write first (after reset), then mem write.
  - alu_ready_o or mem_ready_o is low for exactly one cycle on the losing source.
- ALU streaming valid on every cycle with rd=0..7 and mem idle → 8 consecutive strobes 0x1, 0x2, …, 0x80 with matching data, and alu_ready_o held high throughout (refill on drain).
- Continuous contention for 6 cycles with WB_RR_EN → grants alternate ALU, mem, ALU, mem, ALU, mem. With the macro undefined → 6 mem grants and the ALU slot held with alu_ready_o=0.
- With an integrated register_cell at r9 (w_reserve set), write rd=9, data=0x1234 → cell data becomes 0x1234 and w_reserve_o=0 at edge k+2.

Source files
------------

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter merging ALU and load results into the register-file write port
// Define WB_RR_EN for round-robin arbitration; otherwise loads have fixed priority over ALU results.
module wb_arbiter #(
  parameter int W_OPR  = 32,
  parameter int N_REG  = 32,
  parameter int W_RIDX = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid_i,
  output logic              alu_ready_o,
  input  logic [W_RIDX-1:0] alu_rd_i,
  input  logic [W_OPR-1:0]  alu_data_i,
  input  logic              mem_valid_i,
  output logic              mem_ready_o,
  input  logic [W_RIDX-1:0] mem_rd_i,
  input  logic [W_OPR-1:0]  mem_data_i,
  output logic [N_REG-1:0]  wb_o,
  output logic [W_OPR-1:0]  wb_data_o,
  output logic              wb_busy_o
);

  logic              alu_v_q, alu_v_d;
  logic [W_RIDX-1:0] alu_rd_q, alu_rd_d;
  logic [W_OPR-1:0]  alu_data_q, alu_data_d;
  logic              mem_v_q, mem_v_d;
  logic [W_RIDX-1:0] mem_rd_q, mem_rd_d;
  logic [W_OPR-1:0]  mem_data_q, mem_data_d;
  logic [N_REG-1:0]  wb_q, wb_d;
  logic [W_OPR-1:0]  wb_data_q, wb_data_d;
  logic              gnt_alu, gnt_mem;

`ifdef WB_RR_EN
  // last_mem_q high means mem was granted most recently, so ALU wins the next contention
  logic last_mem_q, last_mem_d;

  always_comb begin
    gnt_alu = alu_v_q & (~mem_v_q | last_mem_q);
    gnt_mem = mem_v_q & ~gnt_alu;
  end

  always_comb begin
    last_mem_d = last_mem_q;
    if (gnt_mem) last_mem_d = 1'b1;
    else if (gnt_alu) last_mem_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_mem_q <= 1'b1;
    else      last_mem_q <= last_mem_d;
  end
`else
  always_comb begin
    gnt_mem = mem_v_q;
    gnt_alu = alu_v_q & ~mem_v_q;
  end
`endif

  assign alu_ready_o = ~alu_v_q | gnt_alu;
  assign mem_ready_o = ~mem_v_q | gnt_mem;
  assign wb_busy_o   = alu_v_q | mem_v_q;
  assign wb_o        = wb_q;
  assign wb_data_o   = wb_data_q;

  // Drain before fill so a granted slot can be refilled on the same edge
  always_comb begin
    alu_v_d    = alu_v_q;
    alu_rd_d   = alu_rd_q;
    alu_data_d = alu_data_q;
    if (gnt_alu) alu_v_d = 1'b0;
    if (alu_valid_i && alu_ready_o) begin
      alu_v_d    = 1'b1;
      alu_rd_d   = alu_rd_i;
      alu_data_d = alu_data_i;
    end
  end

  always_comb begin
    mem_v_d    = mem_v_q;
    mem_rd_d   = mem_rd_q;
    mem_data_d = mem_data_q;
    if (gnt_mem) mem_v_d = 1'b0;
    if (mem_valid_i && mem_ready_o) begin
      mem_v_d    = 1'b1;
      mem_rd_d   = mem_rd_i;
      mem_data_d = mem_data_i;
    end
  end

  always_comb begin
    wb_d      = '0;
    wb_data_d = wb_data_q;
    if (gnt_alu) begin
      wb_d[alu_rd_q] = 1'b1;
      wb_data_d      = alu_data_q;
    end else if (gnt_mem) begin
      wb_d[mem_rd_q] = 1'b1;
      wb_data_d      = mem_data_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_v_q    <= 1'b0;
      alu_rd_q   <= '0;
      alu_data_q <= '0;
      mem_v_q    <= 1'b0;
      mem_rd_q   <= '0;
      mem_data_q <= '0;
      wb_q       <= '0;
      wb_data_q  <= '0;
    end else begin
      alu_v_q    <= alu_v_d;
      alu_rd_q   <= alu_rd_d;
      alu_data_q <= alu_data_d;
      mem_v_q    <= mem_v_d;
      mem_rd_q   <= mem_rd_d;
      mem_data_q <= mem_data_d;
      wb_q       <= wb_d;
      wb_data_q  <= wb_data_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter (expectations follow WB_RR_EN when defined)
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid_i, mem_valid_i;
  logic        alu_ready_o, mem_ready_o;
  logic [4:0]  alu_rd_i, mem_rd_i;
  logic [31:0] alu_data_i, mem_data_i;
  logic [31:0] wb_o, wb_data_o;
  logic        wb_busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  wb_arbiter #(.W_OPR(32), .N_REG(32), .W_RIDX(5)) dut (
    .clk(clk), .rst(rst),
    .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
    .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o), .mem_rd_i(mem_rd_i), .mem_data_i(mem_data_i),
    .wb_o(wb_o), .wb_data_o(wb_data_o), .wb_busy_o(wb_busy_o)
  );

  always #5 clk = ~clk;

  // Minimal register cell on r9: write-back strobe loads data and clears the reserve bit
  logic        cell_set = 1'b0;
  logic        cell_res = 1'b0;
  logic [31:0] cell_data = 32'h0;
  always @(posedge clk) begin
    if (cell_set) cell_res <= 1'b1;
    else if (wb_o[9]) begin
      cell_data <= wb_data_o;
      cell_res  <= 1'b0;
    end
  end

  typedef struct {
    logic        av; logic [4:0] ard; logic [31:0] adata;
    logic        mv; logic [4:0] mrd; logic [31:0] mdata;
    logic        e_ardy, e_mrdy, e_busy;
    logic [31:0] e_wb, e_data;
  } vec_t;

  typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] mdata);
    alu_valid_i = av; alu_rd_i = ard; alu_data_i = adata;
    mem_valid_i = mv; mem_rd_i = mrd; mem_data_i = mdata;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  vec_t vecs[7];
  bit   rr;
  logic [31:0] wbs[$];

  initial begin
`ifdef WB_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);

    // Vector table: applied from a fresh reset, one row per cycle, checked before the edge
    vecs[0] = '{1, 1, 32'h11, 1, 2, 32'h22, 1, 1, 0, 32'h0, 32'h0};
    vecs[1] = '{0, 0, 0, 0, 0, 0, rr, !rr, 1, 32'h0, 32'h0};
    vecs[2] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, rr ? 32'h2 : 32'h4, rr ? 32'h11 : 32'h22};
    vecs[3] = '{1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 1, 0, rr ? 32'h4 : 32'h2, rr ? 32'h22 : 32'h11};
    vecs[4] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h0, rr ? 32'h22 : 32'h11};
    vecs[5] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h20, 32'hDEADBEEF};
    vecs[6] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h0, 32'hDEADBEEF};

    repeat (2) @(negedge clk);
    check("reset_wb", wb_o, 0);
    check("reset_data", wb_data_o, 0);
    check("reset_alu_ready", {31'h0, alu_ready_o}, 1);
    check("reset_mem_ready", {31'h0, mem_ready_o}, 1);
    check("reset_busy", {31'h0, wb_busy_o}, 0);
    rst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(vecs[i].av, vecs[i].ard, vecs[i].adata, vecs[i].mv, vecs[i].mrd, vecs[i].mdata);
      #1;
      check($sformatf("vec%0d_alu_ready", i), {31'h0, alu_ready_o}, {31'h0, vecs[i].e_ardy});
      check($sformatf("vec%0d_mem_ready", i), {31'h0, mem_ready_o}, {31'h0, vecs[i].e_mrdy});
      check($sformatf("vec%0d_busy", i), {31'h0, wb_busy_o}, {31'h0, vecs[i].e_busy});
      check($sformatf("vec%0d_wb", i), wb_o, vecs[i].e_wb);
      check($sformatf("vec%0d_data", i), wb_data_o, vecs[i].e_data);
    end

    // ALU streaming rd=0..7 back to back
    do_reset();
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i < 8) drive(1, 5'(i), 32'h100 + i, 0, 0, 0);
      else drive(0, 0, 0, 0, 0, 0);
      #1;
      if (i < 8) check($sformatf("stream%0d_alu_ready", i), {31'h0, alu_ready_o}, 1);
      if (i >= 2 && i < 10) begin
        check($sformatf("stream%0d_wb", i - 2), wb_o, 32'h1 << (i - 2));
        check($sformatf("stream%0d_data", i - 2), wb_data_o, 32'h100 + i - 2);
      end
      if (i == 10) check("stream_end_wb", wb_o, 0);
    end

    // Continuous contention for six cycles
    do_reset();
    wbs = {};
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i < 7) drive(1, 1, 32'hA0 + i, 1, 2, 32'hB0 + i);
      else drive(0, 0, 0, 0, 0, 0);
      #1;
      if (i >= 1 && i <= 6)
        check($sformatf("contend%0d_alu_ready", i), {31'h0, alu_ready_o}, rr ? 32'(i % 2) : 32'h0);
      if (wb_o != 0) wbs.push_back(wb_o);
    end
    check("contend_count_ok", {31'h0, wbs.size() >= 6}, 1);
    for (int i = 0; i < 6 && i < wbs.size(); i++)
      check($sformatf("contend_grant%0d", i), wbs[i], rr ? ((i % 2) ? 32'h4 : 32'h2) : 32'h4);

    // Register cell r9 with reservation set
    do_reset();
    @(negedge clk); cell_set = 1'b1;
    @(negedge clk); cell_set = 1'b0;
    #1 check("cell_reserved", {31'h0, cell_res}, 1);
    drive(1, 9, 32'h1234, 0, 0, 0);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("cell_res_k1", {31'h0, cell_res}, 1);
    @(negedge clk);
    check("cell_data_k2", cell_data, 32'h1234);
    check("cell_res_k2", {31'h0, cell_res}, 0);

    // Asynchronous reset with one slot still full and a strobe on the output
    do_reset();
    @(negedge clk); drive(1, 3, 32'h33, 1, 7, 32'h77);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("prereset_wb", wb_o, rr ? 32'h8 : 32'h80);
    rst = 1'b0;
    #1;
    check("async_reset_wb", wb_o, 0);
    check("async_reset_data", wb_data_o, 0);
    check("async_reset_alu_ready", {31'h0, alu_ready_o}, 1);
    check("async_reset_mem_ready", {31'h0, mem_ready_o}, 1);
    check("async_reset_busy", {31'h0, wb_busy_o}, 0);
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check($sformatf("postreset%0d_wb", i), wb_o, 0);
    end

    // Randomised traffic against a queue-based reference model
    do_reset();
    begin
      ent_t aq[$], mq[$];
      int   last_src = 1;
      logic [31:0] exp_wb = 0, exp_data = 0;
      for (int c = 0; c < 400; c++) begin
        bit ga, gm, ardy, mrdy;
        @(negedge clk);
        drive(1'($urandom_range(0, 1)), 5'($urandom), $urandom,
              1'($urandom_range(0, 1)), 5'($urandom), $urandom);
        #1;
        ga = 0; gm = 0;
        if (aq.size() != 0 && mq.size() != 0) begin
          if (rr) begin
            if (last_src == 1) ga = 1; else gm = 1;
          end else gm = 1;
        end else if (aq.size() != 0) ga = 1;
        else if (mq.size() != 0) gm = 1;
        ardy = (aq.size() == 0) || ga;
        mrdy = (mq.size() == 0) || gm;
        check("rand_alu_ready", {31'h0, alu_ready_o}, {31'h0, ardy});
        check("rand_mem_ready", {31'h0, mem_ready_o}, {31'h0, mrdy});
        check("rand_busy", {31'h0, wb_busy_o}, {31'h0, (aq.size() + mq.size()) != 0});
        check("rand_wb", wb_o, exp_wb);
        check("rand_data", wb_data_o, exp_data);
        if (ga) begin
          exp_wb = 32'h1 << aq[0].rd; exp_data = aq[0].data; void'(aq.pop_front()); last_src = 0;
        end else if (gm) begin
          exp_wb = 32'h1 << mq[0].rd; exp_data = mq[0].data; void'(mq.pop_front()); last_src = 1;
        end else exp_wb = 0;
        if (alu_valid_i && ardy) aq.push_back('{alu_rd_i, alu_data_i});
        if (mem_valid_i && mrdy) mq.push_back('{mem_rd_i, mem_data_i});
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
